// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction-sequencing controller: fetch/decode/execute FSM driving
// memory, register-file and ALU strobes. Define CTRL_TRAP_EN to trap on opcode 15.
module ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  input  logic        neg,
  input  logic        zero,
  output logic [15:0] ir,
  output logic [3:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        trap,
  output logic [15:0] instret
);

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EX, S_WB_ALU, S_EX_LD, S_MEM_LD, S_WB_LD,
    S_EX_ST, S_MEM_ST, S_BR, S_BR_TAKE, S_BR_NOT, S_EX_JAL, S_WB_JAL, S_EX_JR,
    S_HALT, S_TRAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [15:0] r_instret;
  logic [3:0]  w_op;

  assign w_op    = r_ir[15:12];
  assign ir      = r_ir;
  assign instret = r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (ir_we) r_ir <= instr;
      if (pc_we) r_instret <= r_instret + 16'd1;
    end
  end

  // Outputs decode purely from state (plus mem_ack in the handshake states),
  // so an asynchronous reset to IDLE drops every strobe immediately.
  always_comb begin
    w_next   = r_state;
    alu_op   = '0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    halted   = 1'b0;
    trap     = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_op)
          4'd8:        w_next = S_EX_LD;
          4'd9:        w_next = S_EX_ST;
          4'd10, 4'd11: w_next = S_BR;
          4'd12:       w_next = S_EX_JAL;
          4'd13:       w_next = S_EX_JR;
          4'd14:       w_next = S_HALT;
          4'd15: begin
`ifdef CTRL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next = S_BR_NOT;
`endif
          end
          default:     w_next = S_EX;
        endcase
      end
      S_EX: begin
        alu_op = w_op;
        w_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        alu_op = 4'd10;
        rf_we  = 1'b1;
        wb_sel = 2'd0;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_EX_LD: begin
        alu_op = 4'd8;
        w_next = S_MEM_LD;
      end
      S_MEM_LD: begin
        alu_op   = 4'd8;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) w_next = S_WB_LD;
      end
      S_WB_LD: begin
        alu_op = 4'd10;
        rf_we  = 1'b1;
        wb_sel = 2'd1;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_EX_ST: begin
        alu_op = 4'd9;
        w_next = S_MEM_ST;
      end
      S_MEM_ST: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          alu_op = 4'd10;
          pc_we  = 1'b1;
          w_next = S_FETCH;
        end else begin
          alu_op = 4'd9;
        end
      end
      // opcode bit 0 selects the flag: 10 (bz) tests zero, 11 (bn) tests neg
      S_BR: w_next = (w_op[0] ? neg : zero) ? S_BR_TAKE : S_BR_NOT;
      S_BR_TAKE: begin
        alu_op = 4'd11;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_BR_NOT: begin
        alu_op = 4'd10;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_EX_JAL: begin
        alu_op = 4'd10;
        rf_we  = 1'b1;
        wb_sel = 2'd2;
        w_next = S_WB_JAL;
      end
      S_WB_JAL: begin
        alu_op = 4'd12;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_EX_JR: begin
        alu_op = 4'd13;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: begin
`ifdef CTRL_TRAP_EN
        trap = 1'b1;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm; inputs change 1 ns after the rising
// edge and outputs are compared 1 ns later.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        mem_ack, neg, zero;
  logic [15:0] ir, instret;
  logic [3:0]  alu_op;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, halted, trap;
  logic [1:0]  wb_sel;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] exp_cnt  = '0;

  ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack), .neg(neg), .zero(zero),
    .ir(ir), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Enters from FETCH with mem_ack=1 and returns in the following FETCH.
  task automatic run_branch(input logic [15:0] ins, input logic z, input logic n,
                            input logic [3:0] exp_op, input string tag);
    instr = ins; zero = z; neg = n;
    tick();                                  // DECODE
    tick(); #1;                              // BR
    chk({tag, "_br_pcwe"}, {15'd0, pc_we}, 16'd0);
    tick(); #1;                              // BR_TAKE / BR_NOT
    chk({tag, "_aluop"}, {12'd0, alu_op}, {12'd0, exp_op});
    chk({tag, "_pcwe"}, {15'd0, pc_we}, 16'd1);
    tick(); #1;                              // FETCH
    exp_cnt++;
    chk({tag, "_instret"}, instret, exp_cnt);
    chk({tag, "_fetch"}, {15'd0, mem_req}, 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; instr = 16'h0123; mem_ack = 1'b1; neg = 1'b0; zero = 1'b0;
    #12;
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_instret", instret, 16'h0000);
    tick();
    rst_n = 1'b1; #1;
    chk("idle_mem_req", {15'd0, mem_req}, 16'd0);
    tick(); #1;                              // FETCH
    chk("fetch_mem_req", {15'd0, mem_req}, 16'd1);
    chk("fetch_ir_we", {15'd0, ir_we}, 16'd1);
    chk("fetch_addr_sel", {15'd0, addr_sel}, 16'd0);
    tick(); #1;                              // DECODE
    chk("dec_ir", ir, 16'h0123);
    chk("dec_mem_req", {15'd0, mem_req}, 16'd0);
    tick(); #1;                              // EX
    chk("ex_pc_we", {15'd0, pc_we}, 16'd0);
    chk("ex_rf_we", {15'd0, rf_we}, 16'd0);
    tick(); #1;                              // WB_ALU
    chk("wba_rf_we", {15'd0, rf_we}, 16'd1);
    chk("wba_pc_we", {15'd0, pc_we}, 16'd1);
    chk("wba_aluop", {12'd0, alu_op}, 16'd10);
    chk("wba_instret_pre", instret, 16'd0);
    tick(); #1;                              // FETCH
    exp_cnt = 16'd1;
    chk("add_instret", instret, exp_cnt);

    // load with three wait states in MEM_LD
    instr = 16'h8456; #1;
    chk("ld_fetch_ir_we", {15'd0, ir_we}, 16'd1);
    tick();                                  // DECODE
    mem_ack = 1'b0; #1;
    chk("ld_dec_ir", ir, 16'h8456);
    tick(); #1;                              // EX_LD
    chk("exld_aluop", {12'd0, alu_op}, 16'd8);
    chk("exld_mem_req", {15'd0, mem_req}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_ack = 1'b1;
      #1;
      chk("memld_mem_req", {15'd0, mem_req}, 16'd1);
      chk("memld_addr_sel", {15'd0, addr_sel}, 16'd1);
    end
    tick(); #1;                              // WB_LD
    chk("wbld_rf_we", {15'd0, rf_we}, 16'd1);
    chk("wbld_wb_sel", {14'd0, wb_sel}, 16'd1);
    chk("wbld_mem_req", {15'd0, mem_req}, 16'd0);
    tick(); #1;
    exp_cnt++;
    chk("ld_instret", instret, exp_cnt);

    run_branch(16'hA040, 1'b1, 1'b0, 4'd11, "bz_taken");
    run_branch(16'hA040, 1'b0, 1'b0, 4'd10, "bz_not");
    run_branch(16'hB000, 1'b0, 1'b1, 4'd11, "bn_taken");

    // store, acknowledged on the first MEM_ST cycle
    instr = 16'h9000;
    tick();                                  // DECODE
    mem_ack = 1'b0;
    tick(); #1;                              // EX_ST
    chk("exst_aluop", {12'd0, alu_op}, 16'd9);
    tick(); #1;                              // MEM_ST
    chk("memst_we", {15'd0, mem_we}, 16'd1);
    chk("memst_aluop", {12'd0, alu_op}, 16'd9);
    chk("memst_pc_we", {15'd0, pc_we}, 16'd0);
    mem_ack = 1'b1; #1;
    chk("memst_ack_pc_we", {15'd0, pc_we}, 16'd1);
    chk("memst_ack_aluop", {12'd0, alu_op}, 16'd10);
    tick(); #1;
    exp_cnt++;
    chk("st_instret", instret, exp_cnt);

    // jal
    instr = 16'hC000;
    tick();
    tick(); #1;                              // EX_JAL
    chk("exjal_rf_we", {15'd0, rf_we}, 16'd1);
    chk("exjal_wb_sel", {14'd0, wb_sel}, 16'd2);
    chk("exjal_pc_we", {15'd0, pc_we}, 16'd0);
    tick(); #1;                              // WB_JAL
    chk("wbjal_aluop", {12'd0, alu_op}, 16'd12);
    chk("wbjal_pc_we", {15'd0, pc_we}, 16'd1);
    tick(); exp_cnt++;

    // jr: three cycles FETCH to FETCH
    instr = 16'hD000;
    tick();
    tick(); #1;                              // EX_JR
    chk("exjr_aluop", {12'd0, alu_op}, 16'd13);
    chk("exjr_pc_we", {15'd0, pc_we}, 16'd1);
    tick(); #1;
    exp_cnt++;
    chk("jr_fetch", {15'd0, mem_req}, 16'd1);
    chk("jr_instret", instret, exp_cnt);

    // reserved opcode 15
    instr = 16'hF000;
    tick();
    tick(); #1;
`ifdef CTRL_TRAP_EN
    chk("trap_set", {15'd0, trap}, 16'd1);
    chk("trap_pc_we", {15'd0, pc_we}, 16'd0);
    tick(); tick(); #1;
    chk("trap_sticky", {15'd0, trap}, 16'd1);
    chk("trap_mem_req", {15'd0, mem_req}, 16'd0);
    chk("trap_instret", instret, exp_cnt);
    rst_n = 1'b0; #1;
    chk("trap_rst", {15'd0, trap}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick(); exp_cnt = '0;                    // FETCH
`else
    chk("nop_trap", {15'd0, trap}, 16'd0);
    chk("nop_pc_we", {15'd0, pc_we}, 16'd1);
    chk("nop_aluop", {12'd0, alu_op}, 16'd10);
    tick(); #1;
    exp_cnt++;
    chk("nop_fetch", {15'd0, mem_req}, 16'd1);
    chk("nop_instret", instret, exp_cnt);
`endif

    // instret wrap: preload all-ones, retire one arith op
    mem_ack = 1'b0; #1;
    force dut.r_instret = 16'hFFFF;
    #1;
    release dut.r_instret;
    #1;
    chk("wrap_preset", instret, 16'hFFFF);
    instr = 16'h7000; mem_ack = 1'b1;
    tick();                                  // DECODE
    tick(); #1;                              // EX
    chk("ex7_aluop", {12'd0, alu_op}, 16'd7);
    tick();                                  // WB_ALU
    tick(); #1;
    chk("wrap_instret", instret, 16'h0000);

    // reset in the middle of a store
    instr = 16'h9000;
    tick();
    mem_ack = 1'b0;
    tick();
    tick(); #1;                              // MEM_ST waiting
    chk("midst_mem_req", {15'd0, mem_req}, 16'd1);
    rst_n = 1'b0; #1;
    chk("midst_rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("midst_rst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("midst_rst_instret", instret, 16'h0000);
    chk("midst_rst_ir", ir, 16'h0000);
    tick();
    rst_n = 1'b1; #1;
    chk("midst_idle", {15'd0, mem_req}, 16'd0);
    tick(); #1;
    chk("midst_refetch", {15'd0, mem_req}, 16'd1);
    tick(); #1;
    chk("fetch_hold", {15'd0, mem_req}, 16'd1);
    chk("fetch_hold_ir_we", {15'd0, ir_we}, 16'd0);

    // halt is terminal
    instr = 16'hE000; mem_ack = 1'b1;
    tick();
    tick(); #1;
    chk("halt_set", {15'd0, halted}, 16'd1);
    tick(); tick(); tick(); #1;
    chk("halt_sticky", {15'd0, halted}, 16'd1);
    chk("halt_mem_req", {15'd0, mem_req}, 16'd0);
    chk("halt_pc_we", {15'd0, pc_we}, 16'd0);
    chk("halt_instret", instret, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
